// File: rtl/loop_fetch_select_if.sv
// Bundle between the loop fetch-select stage and its neighbours: the
// instruction-memory stream, the loop FSM / micro-op cache, decode and fetch.
// slave  : the fetch-select stage itself.
// master : the surrounding logic that drives fetch, loop and decode inputs.
interface loop_fetch_select_if;
   localparam int unsigned XLEN = 32;

   // instruction-memory stream
   logic            imem_valid;
   logic [XLEN-1:0] imem_instr;
   logic [XLEN-1:0] imem_pc;
   // loop FSM / micro-op cache
   logic            loop_active;
   logic [XLEN-1:0] loop_instr;
   logic [XLEN-1:0] loop_start_pc;
   logic [XLEN-1:0] loop_end_pc;
   logic            flush;
   logic [XLEN-1:0] resume_pc;
   // decode handshake
   logic            dec_ready;
   logic            dec_valid;
   logic [XLEN-1:0] dec_instr;
   logic [XLEN-1:0] dec_pc;
   logic            dec_from_loop;
   // fetch control
   logic            fetch_stall;
   logic            pc_redirect;
   logic [XLEN-1:0] redirect_pc;
   logic            overflow;

   modport master (
      output imem_valid, imem_instr, imem_pc,
      output loop_active, loop_instr, loop_start_pc, loop_end_pc,
      output flush, resume_pc, dec_ready,
      input  dec_valid, dec_instr, dec_pc, dec_from_loop,
      input  fetch_stall, pc_redirect, redirect_pc, overflow
   );

   modport slave (
      input  imem_valid, imem_instr, imem_pc,
      input  loop_active, loop_instr, loop_start_pc, loop_end_pc,
      input  flush, resume_pc, dec_ready,
      output dec_valid, dec_instr, dec_pc, dec_from_loop,
      output fetch_stall, pc_redirect, redirect_pc, overflow
   );
endinterface

// File: rtl/loop_fetch_select.sv
// Fetch-side selection stage: picks the imem stream or the replayed loop
// stream, rebuilds replay PCs, queues entries in a DEPTH-entry FIFO towards
// decode and converts a loop flush into a one-cycle PC redirect.
// Ports:
//   clk    - clock, all logic on posedge
//   reset  - synchronous active-high reset
//   bus    - loop_fetch_select_if.slave (imem, loop FSM, decode, fetch control)
// DEPTH must be a power of two, minimum 2.
module loop_fetch_select #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   loop_fetch_select_if.slave  bus
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned CW   = AW + 1;

   typedef enum logic [1:0] {FETCH, REPLAY, REDIRECT} state_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic            from_loop;
   } entry_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] replay_pc_q, replay_pc_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   logic            pc_redirect_q, pc_redirect_d;
   logic            loop_prev_q, loop_prev_d;
   logic            overflow_q, overflow_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   entry_t          mem_q [DEPTH];

   logic            push_req;
   entry_t          push_entry;
   logic            wr_en;
   logic            pop;
   logic            full;
   logic            head_valid;
   entry_t          head;

   // Source selection, replay PC reconstruction and flush-to-redirect.
   always_comb begin
      state_d       = state_q;
      replay_pc_d   = replay_pc_q;
      pc_redirect_d = 1'b0;
      redirect_pc_d = redirect_pc_q;
      loop_prev_d   = bus.loop_active;
      push_req      = 1'b0;
      push_entry    = '0;

      if (bus.flush) begin
         // flush outranks any loop entry or push this cycle
         state_d       = REDIRECT;
         pc_redirect_d = 1'b1;
         redirect_pc_d = bus.resume_pc;
      end else begin
         case (state_q)
            FETCH: begin
               if (bus.imem_valid) begin
                  push_req   = 1'b1;
                  push_entry = '{instr: bus.imem_instr, pc: bus.imem_pc, from_loop: 1'b0};
               end
               if (bus.loop_active) begin
                  state_d     = REPLAY;
                  replay_pc_d = bus.loop_start_pc;
               end
            end
            REPLAY: begin
               // BRAM read data lags loop_active by one cycle
               if (bus.loop_active && loop_prev_q) begin
                  push_req    = 1'b1;
                  push_entry  = '{instr: bus.loop_instr, pc: replay_pc_q, from_loop: 1'b1};
                  replay_pc_d = (replay_pc_q == bus.loop_end_pc) ? bus.loop_start_pc
                                                                 : replay_pc_q + XLEN'(4);
               end
               if (!bus.loop_active) state_d = FETCH;
            end
            REDIRECT: state_d = FETCH;  // wrong-path imem data dropped here
            default:  state_d = FETCH;
         endcase
      end
   end

   // FIFO pointer/count update; a full FIFO still accepts a push when it pops.
   always_comb begin
      full       = (count_q == CW'(DEPTH));
      pop        = head_valid & bus.dec_ready;
      wr_en      = 1'b0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         wr_en = push_req & (~full | pop);
         if (push_req & full & ~pop) overflow_d = 1'b1;
         if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(wr_en) - CW'(pop);
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= FETCH;
         replay_pc_q   <= '0;
         redirect_pc_q <= '0;
         pc_redirect_q <= 1'b0;
         loop_prev_q   <= 1'b0;
         overflow_q    <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         replay_pc_q   <= replay_pc_d;
         redirect_pc_q <= redirect_pc_d;
         pc_redirect_q <= pc_redirect_d;
         loop_prev_q   <= loop_prev_d;
         overflow_q    <= overflow_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   // FIFO storage; contents only matter while count covers them.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= push_entry;
   end

   // Head entry is masked to zero while empty so outputs read 0 after reset.
   assign head_valid        = (count_q != '0);
   assign head              = mem_q[rd_ptr_q];
   assign bus.dec_valid     = head_valid;
   assign bus.dec_instr     = head_valid ? head.instr : '0;
   assign bus.dec_pc        = head_valid ? head.pc : '0;
   assign bus.dec_from_loop = head_valid & head.from_loop;
   assign bus.fetch_stall   = (count_q >= CW'(DEPTH - 1)) | (state_q != FETCH);
   assign bus.pc_redirect   = pc_redirect_q;
   assign bus.redirect_pc   = redirect_pc_q;
   assign bus.overflow      = overflow_q;

endmodule

// File: tb/tb_loop_fetch_select.sv
// Self-checking bench for loop_fetch_select: directed scenarios plus a random
// run, all compared each cycle against a queue-based reference model.
module tb_loop_fetch_select;
   localparam int unsigned DEPTH = 4;
   localparam int M_FETCH    = 0;
   localparam int M_REPLAY   = 1;
   localparam int M_REDIRECT = 2;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        lp;
   } ment_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   loop_fetch_select_if bus_if ();

   loop_fetch_select #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state
   ment_t       mq[$];
   int          m_mode     = M_FETCH;
   logic        m_prev     = 1'b0;
   logic [31:0] m_rpc      = 32'h0;
   logic        m_ovf      = 1'b0;
   logic        m_redir    = 1'b0;
   logic [31:0] m_redir_pc = 32'h0;

   logic [100:0] obs;
   assign obs = {bus_if.dec_valid, bus_if.dec_instr, bus_if.dec_pc, bus_if.dec_from_loop,
                 bus_if.fetch_stall, bus_if.pc_redirect, bus_if.redirect_pc, bus_if.overflow};

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_step();
      logic  do_pop;
      logic  do_push;
      ment_t e;
      if (reset) begin
         mq.delete();
         m_mode = M_FETCH; m_prev = 1'b0; m_rpc = 32'h0;
         m_ovf = 1'b0; m_redir = 1'b0; m_redir_pc = 32'h0;
         return;
      end
      do_pop  = (mq.size() != 0) && bus_if.dec_ready;
      do_push = 1'b0;
      e       = '{instr: 32'h0, pc: 32'h0, lp: 1'b0};
      m_redir = 1'b0;
      if (bus_if.flush) begin
         mq.delete();
         m_mode     = M_REDIRECT;
         m_redir    = 1'b1;
         m_redir_pc = bus_if.resume_pc;
      end else begin
         if (m_mode == M_FETCH) begin
            if (bus_if.imem_valid) begin
               do_push = 1'b1;
               e = '{instr: bus_if.imem_instr, pc: bus_if.imem_pc, lp: 1'b0};
            end
            if (bus_if.loop_active) begin
               m_mode = M_REPLAY;
               m_rpc  = bus_if.loop_start_pc;
            end
         end else if (m_mode == M_REPLAY) begin
            if (bus_if.loop_active && m_prev) begin
               do_push = 1'b1;
               e = '{instr: bus_if.loop_instr, pc: m_rpc, lp: 1'b1};
               if (m_rpc == bus_if.loop_end_pc) m_rpc = bus_if.loop_start_pc;
               else                             m_rpc = m_rpc + 32'd4;
            end
            if (!bus_if.loop_active) m_mode = M_FETCH;
         end else begin
            m_mode = M_FETCH;
         end
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            if (mq.size() < int'(DEPTH)) mq.push_back(e);
            else m_ovf = 1'b1;
         end
      end
      m_prev = bus_if.loop_active;
   endtask

   function automatic logic [100:0] exp_vec();
      ment_t h;
      logic  v;
      logic  st;
      h  = '{instr: 32'h0, pc: 32'h0, lp: 1'b0};
      v  = (mq.size() != 0);
      if (v) h = mq[0];
      st = (mq.size() >= int'(DEPTH) - 1) || (m_mode != M_FETCH);
      return {v, h.instr, h.pc, h.lp, st, m_redir, m_redir_pc, m_ovf};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive_idle();
      reset                = 1'b0;
      bus_if.imem_valid    = 1'b0;
      bus_if.imem_instr    = 32'h0;
      bus_if.imem_pc       = 32'h0;
      bus_if.loop_active   = 1'b0;
      bus_if.loop_instr    = 32'h0;
      bus_if.flush         = 1'b0;
      bus_if.resume_pc     = 32'h0;
      bus_if.dec_ready     = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      bus_if.loop_start_pc = 32'h0;
      bus_if.loop_end_pc   = 32'h0;
      reset = 1'b1;
      tick(); tick();
      n_checks++;
      if (obs !== 101'h0) $display("FAIL reset_outputs: got %h expected 0", obs);
      else n_pass++;
      reset = 1'b0;
      tick();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL reset_idle: got %h expected %h", obs, exp_vec());
      else n_pass++;
   endtask

   task automatic test_straight_line();
      logic [31:0] pcs [3] = '{32'h100, 32'h104, 32'h108};
      drive_idle();
      bus_if.dec_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus_if.imem_valid = 1'b1;
         bus_if.imem_instr = $urandom;
         bus_if.imem_pc    = pcs[i];
         tick();
         n_checks++;
         if (bus_if.dec_valid !== 1'b1 || bus_if.dec_pc !== pcs[i] || bus_if.dec_from_loop !== 1'b0)
            $display("FAIL straight_pc[%0d]: got v=%b pc=%h loop=%b expected v=1 pc=%h loop=0",
                     i, bus_if.dec_valid, bus_if.dec_pc, bus_if.dec_from_loop, pcs[i]);
         else n_pass++;
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL straight_model[%0d]: got %h expected %h", i, obs, exp_vec());
         else n_pass++;
      end
      bus_if.imem_valid = 1'b0;
      tick();
      n_checks++;
      if (bus_if.dec_valid !== 1'b0) $display("FAIL straight_drain: got %b expected 0", bus_if.dec_valid);
      else n_pass++;
   endtask

   task automatic test_loop_replay();
      logic [31:0] want;
      drive_idle();
      bus_if.dec_ready     = 1'b1;
      bus_if.loop_start_pc = 32'h200;
      bus_if.loop_end_pc   = 32'h20C;
      for (int k = 1; k <= 10; k++) begin
         bus_if.loop_active = 1'b1;
         bus_if.loop_instr  = $urandom;
         bus_if.imem_valid  = (k > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         bus_if.imem_pc     = $urandom;
         tick();
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL replay_model[%0d]: got %h expected %h", k, obs, exp_vec());
         else n_pass++;
         n_checks++;
         if (k == 1) begin
            if (bus_if.dec_valid !== 1'b0 || bus_if.fetch_stall !== 1'b1)
               $display("FAIL replay_wait: got v=%b stall=%b expected v=0 stall=1",
                        bus_if.dec_valid, bus_if.fetch_stall);
            else n_pass++;
         end else begin
            want = 32'h200 + 32'(4 * ((k - 2) % 4));
            if (bus_if.dec_valid !== 1'b1 || bus_if.dec_pc !== want ||
                bus_if.dec_from_loop !== 1'b1 || bus_if.fetch_stall !== 1'b1)
               $display("FAIL replay_pc[%0d]: got v=%b pc=%h loop=%b stall=%b expected v=1 pc=%h loop=1 stall=1",
                        k, bus_if.dec_valid, bus_if.dec_pc, bus_if.dec_from_loop, bus_if.fetch_stall, want);
            else n_pass++;
         end
      end
      bus_if.loop_active = 1'b0;
      bus_if.imem_valid  = 1'b0;
      tick();
      n_checks++;
      if (bus_if.dec_valid !== 1'b0 || bus_if.fetch_stall !== 1'b0)
         $display("FAIL replay_exit: got v=%b stall=%b expected v=0 stall=0",
                  bus_if.dec_valid, bus_if.fetch_stall);
      else n_pass++;
   endtask

   task automatic test_flush();
      drive_idle();
      bus_if.loop_start_pc = 32'h200;
      bus_if.loop_end_pc   = 32'h20C;
      bus_if.loop_active   = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus_if.loop_instr = $urandom;
         tick();
      end
      bus_if.flush       = 1'b1;
      bus_if.resume_pc   = 32'h210;
      bus_if.loop_active = 1'b0;
      tick();
      n_checks++;
      if (bus_if.pc_redirect !== 1'b1 || bus_if.redirect_pc !== 32'h210 || bus_if.dec_valid !== 1'b0)
         $display("FAIL flush_redirect: got red=%b pc=%h v=%b expected red=1 pc=00000210 v=0",
                  bus_if.pc_redirect, bus_if.redirect_pc, bus_if.dec_valid);
      else n_pass++;
      bus_if.flush      = 1'b0;
      bus_if.imem_valid = 1'b1;
      bus_if.imem_pc    = 32'hDEAD0;
      bus_if.imem_instr = $urandom;
      tick();
      n_checks++;
      if (bus_if.pc_redirect !== 1'b0 || bus_if.dec_valid !== 1'b0 || bus_if.fetch_stall !== 1'b0)
         $display("FAIL flush_stale: got red=%b v=%b stall=%b expected 0 0 0",
                  bus_if.pc_redirect, bus_if.dec_valid, bus_if.fetch_stall);
      else n_pass++;
      bus_if.imem_pc    = 32'h210;
      bus_if.dec_ready  = 1'b1;
      tick();
      n_checks++;
      if (bus_if.dec_valid !== 1'b1 || bus_if.dec_pc !== 32'h210 || bus_if.dec_from_loop !== 1'b0)
         $display("FAIL flush_resume: got v=%b pc=%h expected v=1 pc=00000210", bus_if.dec_valid, bus_if.dec_pc);
      else n_pass++;
      // loop entry coinciding with flush must be ignored
      bus_if.imem_valid  = 1'b0;
      bus_if.loop_active = 1'b1;
      bus_if.flush       = 1'b1;
      bus_if.resume_pc   = 32'h400;
      tick();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL flush_vs_loop: got %h expected %h", obs, exp_vec());
      else n_pass++;
      bus_if.flush = 1'b0;
      tick();
      n_checks++;
      if (bus_if.fetch_stall !== 1'b0 || bus_if.dec_valid !== 1'b0)
         $display("FAIL flush_wins: got stall=%b v=%b expected stall=0 v=0", bus_if.fetch_stall, bus_if.dec_valid);
      else n_pass++;
      bus_if.loop_active = 1'b0;
      tick(); tick();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL flush_settle: got %h expected %h", obs, exp_vec());
      else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [31:0] drain [5] = '{32'h508, 32'h50C, 32'h510, 32'h0, 32'h0};
      drive_idle();
      for (int i = 0; i < 4; i++) begin
         bus_if.imem_valid = 1'b1;
         bus_if.imem_pc    = 32'h500 + 32'(4 * i);
         bus_if.imem_instr = $urandom;
         tick();
         n_checks++;
         if (bus_if.fetch_stall !== (i >= 2) || bus_if.overflow !== 1'b0)
            $display("FAIL bp_fill[%0d]: got stall=%b ovf=%b expected stall=%b ovf=0",
                     i, bus_if.fetch_stall, bus_if.overflow, (i >= 2));
         else n_pass++;
      end
      bus_if.dec_ready = 1'b1;
      bus_if.imem_pc   = 32'h510;
      tick();
      n_checks++;
      if (bus_if.overflow !== 1'b0 || bus_if.dec_pc !== 32'h504 || bus_if.fetch_stall !== 1'b1)
         $display("FAIL bp_push_pop_full: got ovf=%b pc=%h stall=%b expected ovf=0 pc=00000504 stall=1",
                  bus_if.overflow, bus_if.dec_pc, bus_if.fetch_stall);
      else n_pass++;
      bus_if.dec_ready = 1'b0;
      bus_if.imem_pc   = 32'h514;
      tick();
      n_checks++;
      if (bus_if.overflow !== 1'b1 || bus_if.dec_pc !== 32'h504)
         $display("FAIL bp_drop: got ovf=%b pc=%h expected ovf=1 pc=00000504", bus_if.overflow, bus_if.dec_pc);
      else n_pass++;
      bus_if.imem_valid = 1'b0;
      bus_if.dec_ready  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (bus_if.dec_valid !== (i < 3) || bus_if.dec_pc !== drain[i] || bus_if.overflow !== 1'b1)
            $display("FAIL bp_drain[%0d]: got v=%b pc=%h ovf=%b expected v=%b pc=%h ovf=1",
                     i, bus_if.dec_valid, bus_if.dec_pc, bus_if.overflow, (i < 3), drain[i]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_replay();
      drive_idle();
      bus_if.loop_start_pc = 32'h600;
      bus_if.loop_end_pc   = 32'h608;
      bus_if.loop_active   = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus_if.loop_instr = $urandom;
         tick();
      end
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL rst_pre: got %h expected %h", obs, exp_vec());
      else n_pass++;
      reset = 1'b1;
      tick();
      n_checks++;
      if (bus_if.dec_valid !== 1'b0 || bus_if.fetch_stall !== 1'b0 ||
          bus_if.overflow !== 1'b0 || bus_if.pc_redirect !== 1'b0 || bus_if.dec_pc !== 32'h0)
         $display("FAIL rst_mid: got v=%b stall=%b ovf=%b red=%b pc=%h expected all 0",
                  bus_if.dec_valid, bus_if.fetch_stall, bus_if.overflow, bus_if.pc_redirect, bus_if.dec_pc);
      else n_pass++;
      reset              = 1'b0;
      bus_if.loop_active = 1'b0;
      tick();
      n_checks++;
      if (obs !== exp_vec()) $display("FAIL rst_post: got %h expected %h", obs, exp_vec());
      else n_pass++;
   endtask

   task automatic test_random();
      int ep_left = 0;
      drive_idle();
      for (int c = 0; c < 600; c++) begin
         reset             = ($urandom_range(0, 199) == 0);
         bus_if.flush      = ($urandom_range(0, 29) == 0);
         bus_if.resume_pc  = 32'($urandom) & 32'hFFFF_FFFC;
         bus_if.dec_ready  = ((c / 64) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) != 0);
         bus_if.imem_valid = 1'($urandom_range(0, 1));
         bus_if.imem_instr = $urandom;
         bus_if.imem_pc    = 32'($urandom) & 32'hFFFF_FFFC;
         bus_if.loop_instr = $urandom;
         if (ep_left > 0) ep_left--;
         else if (!bus_if.loop_active && $urandom_range(0, 7) == 0) begin
            bus_if.loop_start_pc = 32'($urandom) & 32'hFFFF_FFFC;
            bus_if.loop_end_pc   = bus_if.loop_start_pc + 32'(4 * $urandom_range(0, 5));
            ep_left = $urandom_range(1, 20);
         end
         bus_if.loop_active = (ep_left > 0);
         tick();
         n_checks++;
         if (obs !== exp_vec()) $display("FAIL random[%0d]: got %h expected %h", c, obs, exp_vec());
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_straight_line();
      test_loop_replay();
      test_flush();
      test_backpressure();
      test_reset_mid_replay();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/loop_fetch_select.md
# loop_fetch_select

Fetch-side selection stage sitting directly downstream of the loop-detection FSM and its micro-op cache, and upstream of decode. It chooses between the instruction-memory stream and the replayed loop-buffer stream, reconstructs the PC of each replayed instruction, and buffers the result in a small FIFO with a valid/ready handshake to decode. It also turns the FSM's flush into a one-cycle PC redirect for fetch.

## Interface
- DEPTH, 4: output FIFO entries; power of two, minimum 2.
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- imem_valid  in  1  imem_instr/imem_pc valid this cycle.
- imem_instr  in  32  instruction from instruction memory.
- imem_pc  in  32  PC of imem_instr.
- loop_active  in  1  FSM block_signal: replay mode requested.
- loop_instr  in  32  FSM out_instruction (BRAM read data).
- loop_start_pc  in  32  PC of first loop-body instruction; stable while loop_active.
- loop_end_pc  in  32  PC of the closing backward branch; stable while loop_active.
- flush  in  1  FSM flush pulse (mispredict exit).
- resume_pc  in  32  FSM new_pc: loop branch PC + 4.
- dec_ready  in  1  decode accepts head entry.
- dec_valid  out  1  head entry valid.
- dec_instr  out  32  head instruction.
- dec_pc  out  32  head PC.
- dec_from_loop  out  1  head entry came from replay.
- fetch_stall  out  1  hold imem PC and fetch.
- pc_redirect  out  1  one-cycle redirect pulse to fetch.
- redirect_pc  out  32  redirect target, valid with pc_redirect.
- overflow  out  1  sticky: an entry was dropped because FIFO was full.

## Operation
- States: FETCH, REPLAY, REDIRECT. Reset -> FETCH.
- FETCH: push {imem_instr, imem_pc, 0} when imem_valid. loop_active=1 -> REPLAY, replay_pc <= loop_start_pc.
- REPLAY: imem_valid ignored. Replay entry valid when loop_active is 1 this cycle and was 1 the previous cycle (BRAM latency of one). On a valid replay entry push {loop_instr, replay_pc, 1}; replay_pc <= (replay_pc == loop_end_pc) ? loop_start_pc : replay_pc + 4 (32-bit, modulo 2^32). loop_active falling without flush -> FETCH.
- flush=1 in any state: FIFO cleared (count 0, pointers 0), push in that cycle suppressed, pc_redirect=1, redirect_pc=resume_pc, next state REDIRECT. flush has priority over every push and pop.
- REDIRECT: one cycle, no pushes, imem_valid discarded (stale wrong-path fetch) -> FETCH.
- Pop when dec_valid & dec_ready. Push and pop in the same cycle on a full FIFO is allowed: count unchanged, no overflow.
- Push with count == DEPTH and no simultaneous pop: entry dropped, overflow <= 1 (cleared only by reset).
- fetch_stall = (count >= DEPTH-1) | (state != FETCH). Combinational from registered count and state.
- dec_valid = (count != 0); dec_instr/dec_pc/dec_from_loop from the head entry.
- loop_active rising in the same cycle as flush: flush wins; loop entry is ignored.

## Timing
- Reset values: dec_valid 0, dec_instr 0, dec_pc 0, dec_from_loop 0, pc_redirect 0, redirect_pc 0, overflow 0, fetch_stall 0, count 0, replay_pc 0.
- imem or replay entry pushed in cycle N is visible on dec_* in cycle N+1 if FIFO was empty (one-cycle latency).
- First replay entry: loop_active first high in N (FSM WAIT), first push in N+1 with PC loop_start_pc.
- pc_redirect registered: flush in N -> pc_redirect=1 in N+1 only; dec_valid=0 in N+1.
- Reset asserted mid-operation: all state returns to reset values on the next edge; FIFO contents discarded.

## Test plan
- Straight-line fetch: imem_pc 0x100,0x104,0x108 with dec_ready=1 -> dec_pc 0x100,0x104,0x108 one cycle later each, dec_from_loop=0.
- Loop replay: loop_start_pc=0x200, loop_end_pc=0x20C, loop_active high 10 cycles -> 9 entries, dec_pc 0x200,0x204,0x208,0x20C,0x200,..., dec_from_loop=1, fetch_stall=1 throughout.
- Flush exit: during replay assert flush with resume_pc=0x210 -> next cycle pc_redirect=1, redirect_pc=0x210, dec_valid=0; following cycle FETCH, imem entry 0x210 accepted.
- Backpressure: dec_ready=0, 4 imem pushes -> fetch_stall rises when count=3; 5th push dropped, overflow=1; simultaneous push/pop at full -> overflow unchanged.
- Reset mid-replay with 3 entries queued -> next cycle dec_valid=0, state FETCH, overflow=0, pc_redirect=0.
